// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - receive FIFO and 4-phase read server for the TinyBF input path
module uart_rx_ctrl #(
    parameter int          FIFO_AW       = 2,
    parameter logic [15:0] TIMEOUT_TICKS = 16'd0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               baud_tick_16x_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    input  logic               rx_busy_i,
    input  logic               rd_req_i,
    output logic               rd_ack_o,
    output logic [7:0]         rd_data_o,
    output logic               rd_timeout_o,
    input  logic               flush_i,
    input  logic               clr_err_i,
    output logic               overrun_o,
    output logic [FIFO_AW:0]   level_o,
    output logic               rx_active_o
);

    localparam int                 DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] head;
    logic [FIFO_AW-1:0] tail;
    logic [15:0]        tmo_cnt;

    logic               empty;
    logic               full;
    logic               avail;
    logic               pop;
    logic               push;
    logic               drop;
    logic               tmo_hit;
    logic [FIFO_AW:0]   count_nxt;

    // Occupancy is level_o itself; it can only reach DEPTH, so its MSB marks full.
    assign empty   = (level_o == '0);
    assign full    = level_o[FIFO_AW];
    // A flush in the same cycle hides the FIFO contents from the reader.
    assign avail   = !empty && !flush_i;
    assign pop     = avail && rd_req_i && ((state == S_IDLE) || (state == S_WAIT));
    assign push    = rx_valid_i && !flush_i && (!full || pop);
    assign drop    = rx_valid_i && !flush_i && full && !pop;
    assign tmo_hit = (TIMEOUT_TICKS != 16'd0) && (tmo_cnt >= TIMEOUT_TICKS);

    // Next occupancy: flush empties, otherwise push and pop cancel out.
    always_comb begin
        count_nxt = level_o;
        if (flush_i) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = level_o + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = level_o - CNT_ONE;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[tail] <= rx_data_i;
        end
    end

    // Pointers, occupancy, activity and sticky overrun.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head        <= '0;
            tail        <= '0;
            level_o     <= '0;
            rx_active_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (flush_i) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
            end
            level_o     <= count_nxt;
            rx_active_o <= rx_busy_i || (count_nxt != '0);
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clr_err_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    // Read handshake FSM with its registered outputs and the idle-line timer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            tmo_cnt      <= 16'd0;
            rd_ack_o     <= 1'b0;
            rd_data_o    <= 8'h00;
            rd_timeout_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_req_i) begin
                        if (avail) begin
                            rd_data_o    <= mem[head];
                            rd_timeout_o <= 1'b0;
                            rd_ack_o     <= 1'b1;
                            state        <= S_ACK;
                        end else begin
                            tmo_cnt <= 16'd0;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!rd_req_i) begin
                        state <= S_IDLE;
                    end else if (avail) begin
                        rd_data_o    <= mem[head];
                        rd_timeout_o <= 1'b0;
                        rd_ack_o     <= 1'b1;
                        state        <= S_ACK;
                    end else if (tmo_hit) begin
                        rd_data_o    <= 8'h00;
                        rd_timeout_o <= 1'b1;
                        rd_ack_o     <= 1'b1;
                        state        <= S_ACK;
                    end else if (rx_busy_i) begin
                        tmo_cnt <= 16'd0;
                    end else if (baud_tick_16x_i && (tmo_cnt != 16'hFFFF)) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_ACK: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!rd_req_i) begin
                        rd_ack_o     <= 1'b0;
                        rd_timeout_o <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       baud_tick_16x_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_valid_i = 1'b0;
    logic       rx_busy_i = 1'b0;
    logic       rd_req_i = 1'b0;
    logic       rd_ack_o;
    logic [7:0] rd_data_o;
    logic       rd_timeout_o;
    logic       flush_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic       overrun_o;
    logic [2:0] level_o;
    logic       rx_active_o;

    int checks = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [7:0] model_q[$];
    bit         model_ovr = 1'b0;
    logic       ack_prev = 1'b0;

    uart_rx_ctrl #(.FIFO_AW(2), .TIMEOUT_TICKS(16'd32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .baud_tick_16x_i(baud_tick_16x_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_busy_i(rx_busy_i),
        .rd_req_i(rd_req_i), .rd_ack_o(rd_ack_o), .rd_data_o(rd_data_o),
        .rd_timeout_o(rd_timeout_o), .flush_i(flush_i), .clr_err_i(clr_err_i),
        .overrun_o(overrun_o), .level_o(level_o), .rx_active_o(rx_active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every rising ack is one completed read, matched against the scoreboard.
    always @(negedge clk_i) begin
        logic [8:0] e;
        if (rd_ack_o && !ack_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack got data=%0h exp=no read outstanding", rd_data_o);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", {24'd0, rd_data_o}, {24'd0, e[7:0]});
                check("rd_timeout", {31'd0, rd_timeout_o}, {31'd0, e[8]});
            end
        end
        ack_prev = rd_ack_o;
    end

    // Reference FIFO: bounded queue of depth 4 with sticky overrun.
    task automatic push_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        if (model_q.size() < 4) model_q.push_back(b);
        else model_ovr = 1'b1;
        cyc();
        rx_valid_i = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] d, input bit to, output int lat);
        int k;
        exp_q.push_back({to, d});
        rd_req_i = 1'b1;
        lat = 0;
        while (!rd_ack_o && lat < 200) begin
            cyc();
            lat++;
        end
        if (!rd_ack_o) begin
            checks++;
            failures++;
            $display("FAIL read_ack_wait got=no ack exp=ack within 200 cycles");
        end
        cyc();
        rd_req_i = 1'b0;
        k = 0;
        while (rd_ack_o && k < 10) begin
            cyc();
            k++;
        end
        check("ack_fall", {31'd0, rd_ack_o}, 32'd0);
    endtask

    task automatic read_model();
        int lat;
        logic [7:0] d;
        d = model_q.pop_front();
        do_read(d, 1'b0, lat);
        check("read_latency", lat, 1);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, {29'd0, level_o}, model_q.size());
        check({tag, "_overrun"}, {31'd0, overrun_o}, {31'd0, model_ovr});
        check({tag, "_active"}, {31'd0, rx_active_o}, {31'd0, model_q.size() != 0});
    endtask

    task automatic timeout_run(input int busy_at, input int exp_ticks);
        int ntick;
        int got;
        int k;
        bit busy_done;
        ntick = 0;
        got = -1;
        busy_done = 1'b0;
        exp_q.push_back({1'b1, 8'h00});
        rd_req_i = 1'b1;
        cyc();
        for (int i = 0; i < 80 && got < 0; i++) begin
            if (busy_at != 0 && ntick == busy_at && !busy_done) begin
                rx_busy_i = 1'b1;
                cyc();
                rx_busy_i = 1'b0;
                busy_done = 1'b1;
            end
            baud_tick_16x_i = 1'b1;
            cyc();
            baud_tick_16x_i = 1'b0;
            ntick++;
            for (int j = 0; j < 3; j++) begin
                if (rd_ack_o && got < 0) got = ntick;
                cyc();
            end
        end
        check("timeout_ticks", got, exp_ticks);
        rd_req_i = 1'b0;
        k = 0;
        while (rd_ack_o && k < 10) begin
            cyc();
            k++;
        end
        check("timeout_ack_fall", {31'd0, rd_ack_o}, 32'd0);
        check("timeout_flag_clear", {31'd0, rd_timeout_o}, 32'd0);
    endtask

    initial begin
        int lat;
        int n;

        // Reset values
        repeat (3) cyc();
        check("rst_ack", {31'd0, rd_ack_o}, 32'd0);
        check("rst_data", {24'd0, rd_data_o}, 32'd0);
        check("rst_timeout", {31'd0, rd_timeout_o}, 32'd0);
        check("rst_overrun", {31'd0, overrun_o}, 32'd0);
        check("rst_level", {29'd0, level_o}, 32'd0);
        check("rst_active", {31'd0, rx_active_o}, 32'd0);
        rst_i = 1'b1;
        cyc();

        // Two bytes, two reads
        push_byte(8'h41);
        push_byte(8'h42);
        check_status("two");
        read_model();
        check_status("one");
        read_model();
        check_status("zero");

        // Read on empty FIFO, byte arrives late, no ticks so no timeout
        exp_q.push_back({1'b0, 8'h5A});
        rd_req_i = 1'b1;
        repeat (100) cyc();
        check("wait_no_ack", {31'd0, rd_ack_o}, 32'd0);
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h5A;
        cyc();
        rx_valid_i = 1'b0;
        check("wait_no_ack_push_edge", {31'd0, rd_ack_o}, 32'd0);
        cyc();
        check("wait_ack_next", {31'd0, rd_ack_o}, 32'd1);
        check("wait_level", {29'd0, level_o}, 32'd0);
        cyc();
        rd_req_i = 1'b0;
        cyc();
        check("wait_ack_fall", {31'd0, rd_ack_o}, 32'd0);

        // Overrun on fifth byte, then drain and clear
        for (int i = 1; i <= 5; i++) push_byte(i[7:0]);
        check_status("ovr");
        for (int i = 0; i < 4; i++) read_model();
        clr_err_i = 1'b1;
        model_ovr = 1'b0;
        cyc();
        clr_err_i = 1'b0;
        check_status("clr");

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + i[7:0]);
        exp_q.push_back({1'b0, model_q.pop_front()});
        model_q.push_back(8'h77);
        rd_req_i   = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h77;
        cyc();
        rx_valid_i = 1'b0;
        check("full_pp_ack", {31'd0, rd_ack_o}, 32'd1);
        check_status("full_pp");
        cyc();
        rd_req_i = 1'b0;
        cyc();
        check("full_pp_ack_fall", {31'd0, rd_ack_o}, 32'd0);
        for (int i = 0; i < 4; i++) read_model();

        // Idle-line timeout, plain and restarted by a frame in flight
        timeout_run(0, 32);
        timeout_run(20, 52);

        // Activity follows rx_busy while empty
        rx_busy_i = 1'b1;
        cyc();
        check("busy_active", {31'd0, rx_active_o}, 32'd1);
        rx_busy_i = 1'b0;
        cyc();
        check("idle_active", {31'd0, rx_active_o}, 32'd0);

        // Randomized bursts against the reference queue
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                push_byte(8'($urandom));
                repeat ($urandom_range(0, 2)) cyc();
            end
            check_status("rnd_fill");
            while (model_q.size() != 0) read_model();
            clr_err_i = 1'b1;
            model_ovr = 1'b0;
            cyc();
            clr_err_i = 1'b0;
            check_status("rnd_drain");
        end

        // Flush overrides a simultaneous push
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        flush_i    = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h99;
        cyc();
        flush_i    = 1'b0;
        rx_valid_i = 1'b0;
        model_q.delete();
        check_status("flush");

        // Reset in DONE drops everything at once
        push_byte(8'h33);
        exp_q.push_back({1'b0, model_q.pop_front()});
        rd_req_i = 1'b1;
        cyc();
        cyc();
        check("done_ack", {31'd0, rd_ack_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_ack", {31'd0, rd_ack_o}, 32'd0);
        check("arst_data", {24'd0, rd_data_o}, 32'd0);
        check("arst_timeout", {31'd0, rd_timeout_o}, 32'd0);
        check("arst_overrun", {31'd0, overrun_o}, 32'd0);
        check("arst_level", {29'd0, level_o}, 32'd0);
        check("arst_active", {31'd0, rx_active_o}, 32'd0);
        rd_req_i = 1'b0;
        cyc();
        rst_i = 1'b1;
        cyc();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
